// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle for the register-file peripheral.
//   sclk    : SPI clock from the controller (mode 0, idles low)
//   copi    : controller-out data, MSB first
//   ncs     : chip select, active-low
//   cipo    : peripheral-out read data
//   cipo_oe : pad output enable for cipo
// The master modport is the SPI controller side; the slave modport is the peripheral.
interface spi_regfile_peripheral_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output copi, output ncs, input cipo, input cipo_oe);
  modport slave  (input sclk, input copi, input ncs, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register-file peripheral.
// Frame: R/W bit (1=write), ADDR_W address bits, then DATA_W-bit words, all MSB first.
// Writes commit a word into the register file on its last bit; reads stream
// register contents out on cipo. Bursts auto-increment the address.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   spi        : SPI pins (slave modport: sclk/copi/ncs in, cipo/cipo_oe out)
//   reg_q      : flat register contents, reg k at [k*DATA_W +: DATA_W]
//   wr_strobe  : one-cycle pulse per committed register write
//   wr_addr    : address of the committed write, valid with wr_strobe
//   frame_err  : one-cycle pulse when a frame ends mid-field
//   addr_err   : one-cycle pulse when a word targets an address >= NUM_REGS
module spi_regfile_peripheral #(
  parameter int NUM_REGS    = 8,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_regfile_peripheral_if.slave    spi,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err,
  output logic                       addr_err
);

  // One counter serves both the address field and the data-word bit count.
  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0]   NREGS_L   = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_ADDR, S_DATA} state_t;

  // ---------------- input synchronisers + edge detect ----------------
  // ncs chain resets low so a frame already running at reset release never
  // produces a falling edge: ncs has to be seen high first.
  logic [SYNC_STAGES-1:0] sclk_pipe, copi_pipe, ncs_pipe;
  logic                   sclk_d, ncs_d;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, sclk_fall, ncs_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_pipe <= '0;
      copi_pipe <= '0;
      ncs_pipe  <= '0;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b0;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], spi.sclk};
      copi_pipe <= {copi_pipe[SYNC_STAGES-2:0], spi.copi};
      ncs_pipe  <= {ncs_pipe[SYNC_STAGES-2:0],  spi.ncs};
      sclk_d    <= sclk_pipe[SYNC_STAGES-1];
      ncs_d     <= ncs_pipe[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
  assign copi_s    = copi_pipe[SYNC_STAGES-1];
  assign ncs_s     = ncs_pipe[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s &  sclk_d;
  assign ncs_fall  = ~ncs_s  &  ncs_d;

  // ---------------- frame engine ----------------
  state_t                           state;
  logic                             rw;
  logic [ADDR_W-1:0]                addr;
  logic [CNT_W-1:0]                 bit_cnt;   // bits seen in current field (rising edges)
  logic [CNT_W-1:0]                 out_cnt;   // bits driven of current read word (falling edges)
  logic [DATA_W-1:0]                sh_in;
  logic [DATA_W-1:0]                sh_out;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
  logic                             cipo_q, cipo_oe_q;

  logic [DATA_W-1:0] word_in;
  logic [DATA_W-1:0] rd_word;
  logic [ADDR_W-1:0] addr_inc;
  logic [IDX_W-1:0]  idx;
  logic              addr_ok;

  always_comb begin
    word_in  = DATA_W'({sh_in, copi_s});
    addr_ok  = ({1'b0, addr} < NREGS_L);
    idx      = IDX_W'(addr);
    rd_word  = addr_ok ? regs[idx] : '0;
    // In-range addresses wrap inside the file; out-of-range ones just count on.
    addr_inc = (addr_ok && addr == LAST_ADDR) ? '0 : addr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rw        <= 1'b0;
      addr      <= '0;
      bit_cnt   <= '0;
      out_cnt   <= '0;
      sh_in     <= '0;
      sh_out    <= '0;
      regs      <= '0;
      cipo_q    <= 1'b0;
      cipo_oe_q <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      addr_err  <= 1'b0;
      if (ncs_s) begin
        // In ADDR the R/W bit has already arrived, so any abort there is malformed.
        if (state == S_ADDR || (state == S_DATA && bit_cnt != '0))
          frame_err <= 1'b1;
        state     <= S_IDLE;
        cipo_q    <= 1'b0;
        cipo_oe_q <= 1'b0;
        bit_cnt   <= '0;
        out_cnt   <= '0;
      end else if (ncs_fall) begin
        state   <= S_CMD;
        bit_cnt <= '0;
        out_cnt <= '0;
      end else begin
        unique case (state)
          S_IDLE: ;
          S_CMD: if (sclk_rise) begin
            rw    <= copi_s;
            state <= S_ADDR;
          end
          S_ADDR: if (sclk_rise) begin
            addr <= ADDR_W'({addr, copi_s});
            if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
              state     <= S_DATA;
              bit_cnt   <= '0;
              cipo_oe_q <= ~rw;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (sclk_rise) begin
              sh_in <= word_in;
              if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                bit_cnt <= '0;
                if (rw) begin
                  if (addr_ok) begin
                    regs[idx] <= word_in;
                    wr_strobe <= 1'b1;
                    wr_addr   <= addr;
                  end else begin
                    addr_err <= 1'b1;
                  end
                  addr <= addr_inc;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (sclk_fall && !rw) begin
              if (out_cnt == '0) begin
                // Word boundary: fetch the register and present its MSB.
                cipo_q <= rd_word[DATA_W-1];
                sh_out <= rd_word << 1;
                if (!addr_ok) addr_err <= 1'b1;
                if (DATA_W == 1) addr    <= addr_inc;
                else             out_cnt <= CNT_W'(1);
              end else begin
                cipo_q <= sh_out[DATA_W-1];
                sh_out <= sh_out << 1;
                if (out_cnt == CNT_W'(DATA_W - 1)) begin
                  out_cnt <= '0;
                  addr    <= addr_inc;
                end else begin
                  out_cnt <= out_cnt + 1'b1;
                end
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign reg_q       = regs;
  assign spi.cipo    = cipo_q;
  assign spi.cipo_oe = cipo_oe_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
module tb_spi_regfile_peripheral;
  localparam int NR = 8;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int HALF = 8;   // clk periods per SCLK phase

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_regfile_peripheral_if spi();
  logic [NR*DW-1:0] reg_q;
  logic             wr_strobe;
  logic [AW-1:0]    wr_addr;
  logic             frame_err;
  logic             addr_err;

  spi_regfile_peripheral #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi(spi),
    .reg_q(reg_q), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .frame_err(frame_err), .addr_err(addr_err)
  );

  int checks = 0;
  int failures = 0;

  // pulse monitor
  int n_aerr, n_ferr;
  int wrq[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_strobe) wrq.push_back(int'(wr_addr));
      if (addr_err)  n_aerr++;
      if (frame_err) n_ferr++;
    end
  end

  // reference register file
  logic [DW-1:0] mdl[NR];
  logic [DW-1:0] wq[$];     // words to send in the next write frame
  bit            txq[$], rxq[$], oeq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mdl_vec();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < NR; k++) v[k*DW +: DW] = mdl[k];
    return v;
  endfunction

  function automatic int nxt(input int a);
    if (a < NR) return (a == NR-1) ? 0 : a + 1;
    return (a + 1) % (1 << AW);
  endfunction

  // Controller: mode 0, copi set while sclk low, cipo sampled just before sclk rises.
  task automatic run_frame();
    rxq = {}; oeq = {};
    spi.ncs = 1'b0;
    wclk(HALF);
    foreach (txq[i]) begin
      spi.copi = txq[i];
      wclk(HALF);
      rxq.push_back(spi.cipo);
      oeq.push_back(spi.cipo_oe);
      spi.sclk = 1'b1;
      wclk(HALF);
      spi.sclk = 1'b0;
    end
    wclk(HALF);
    spi.ncs  = 1'b1;
    spi.copi = 1'b0;
    wclk(12);
  endtask

  // hdr: header bits actually sent (8 = full header); nbits: data bits sent.
  task automatic do_frame(input string tag, input bit rw, input int a, input int hdr, input int nbits);
    logic [AW-1:0] av;
    logic [DW-1:0] rdw[$];
    int exp_wr[$];
    int exp_aerr, exp_ferr, cur;
    av = AW'(a);
    txq = {};
    txq.push_back(rw);
    for (int b = AW-1; b >= 0; b--) txq.push_back(av[b]);
    while (txq.size() > hdr) void'(txq.pop_back());
    if (hdr < 1 + AW) nbits = 0;
    for (int i = 0; i < nbits; i++) txq.push_back(rw ? wq[i/DW][DW-1-(i%DW)] : 1'b0);

    exp_aerr = 0; exp_ferr = 0; cur = a;
    if (hdr < 1 + AW) begin
      exp_ferr = (hdr >= 1) ? 1 : 0;
    end else if (rw) begin
      for (int w = 0; w < nbits/DW; w++) begin
        if (cur < NR) begin mdl[cur] = wq[w]; exp_wr.push_back(cur); end
        else exp_aerr++;
        cur = nxt(cur);
      end
      exp_ferr = (nbits % DW != 0) ? 1 : 0;
    end else begin
      // a word is fetched at each word boundary, including the trailing one
      for (int j = 0; j <= nbits/DW; j++) begin
        rdw.push_back(cur < NR ? mdl[cur] : '0);
        if (cur >= NR) exp_aerr++;
        cur = nxt(cur);
      end
      exp_ferr = (nbits % DW != 0) ? 1 : 0;
    end

    n_aerr = 0; n_ferr = 0; wrq = {};
    run_frame();

    chk({tag, ".addr_err"},  n_aerr, exp_aerr);
    chk({tag, ".frame_err"}, n_ferr, exp_ferr);
    chk({tag, ".wr_count"},  wrq.size(), exp_wr.size());
    for (int k = 0; k < exp_wr.size() && k < wrq.size(); k++)
      chk($sformatf("%s.wr_addr%0d", tag, k), wrq[k], exp_wr[k]);
    chk({tag, ".reg_q"}, reg_q, mdl_vec());
    for (int i = 0; i < txq.size(); i++) begin
      chk($sformatf("%s.oe%0d", tag, i), oeq[i], (!rw && hdr == 1+AW && i >= 1+AW) ? 1 : 0);
      if (!rw && i >= 1+AW)
        chk($sformatf("%s.cipo%0d", tag, i-1-AW), rxq[i], rdw[(i-1-AW)/DW][DW-1-((i-1-AW)%DW)]);
    end
    chk({tag, ".idle_oe"},   spi.cipo_oe, 0);
    chk({tag, ".idle_cipo"}, spi.cipo, 0);
  endtask

  initial begin
    int rw, a, nw, nb;
    spi.sclk = 1'b0; spi.copi = 1'b0; spi.ncs = 1'b1;
    for (int k = 0; k < NR; k++) mdl[k] = '0;
    rst = 1'b1;
    wclk(4);
    rst = 1'b0;
    wclk(6);

    chk("rst.reg_q", reg_q, 0);
    chk("rst.cipo_oe", spi.cipo_oe, 0);
    chk("rst.wr_strobe", wr_strobe, 0);
    chk("rst.errs", {frame_err, addr_err}, 0);

    // directed steps
    wq = {8'h5A};             do_frame("wr3",      1, 3,    8, 8);
                              do_frame("rd3",      0, 3,    8, 8);
    wq = {8'h11, 8'h22};      do_frame("burst7",   1, 7,    8, 16);
    wq = {8'hFF};             do_frame("wr_oor",   1, 'h10, 8, 8);
                              do_frame("rd_oor",   0, 'h10, 8, 8);
    wq = {8'hC3};             do_frame("wr2_part", 1, 2,    8, 4);
    wq = {8'h3C};             do_frame("wr2",      1, 2,    8, 8);
                              do_frame("addr_abort", 1, 5,  4, 0);
                              do_frame("rd_burst", 0, 6,    8, 24);

    // randomized frames against the model
    for (int t = 0; t < 14; t++) begin
      rw = $urandom_range(0, 1);
      a  = ($urandom_range(0, 3) == 0) ? $urandom_range(NR, (1<<AW)-1) : $urandom_range(0, NR-1);
      nw = $urandom_range(1, 3);
      nb = nw * DW - (($urandom_range(0, 4) == 0) ? $urandom_range(1, DW-1) : 0);
      wq = {};
      for (int w = 0; w < nw; w++) wq.push_back(DW'($urandom));
      do_frame($sformatf("rnd%0d", t), rw[0], a, 8, nb);
    end

    // reset in the middle of a frame with ncs held low
    spi.ncs = 1'b0;
    wclk(HALF);
    for (int i = 0; i < 5; i++) begin
      spi.copi = 1'b1; wclk(HALF); spi.sclk = 1'b1; wclk(HALF); spi.sclk = 1'b0;
    end
    rst = 1'b1;
    wclk(3);
    rst = 1'b0;
    for (int k = 0; k < NR; k++) mdl[k] = '0;
    wclk(2);
    chk("mrst.reg_q", reg_q, 0);
    chk("mrst.outs", {spi.cipo, spi.cipo_oe, wr_strobe, frame_err, addr_err}, 0);
    chk("mrst.wr_addr", wr_addr, 0);
    // a full write frame's worth of clocks while ncs stays low must be ignored
    n_aerr = 0; n_ferr = 0; wrq = {};
    for (int i = 0; i < 16; i++) begin
      spi.copi = (i % 3 == 0); wclk(HALF); spi.sclk = 1'b1; wclk(HALF); spi.sclk = 1'b0;
    end
    wclk(HALF);
    spi.ncs = 1'b1;
    wclk(12);
    chk("ignored.reg_q", reg_q, 0);
    chk("ignored.wr_count", wrq.size(), 0);
    chk("ignored.errs", n_aerr + n_ferr, 0);
    wq = {8'hA5};             do_frame("post_rst", 1, 1, 8, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
